// File: rtl/ram_multiport.sv
// Multi-port word RAM: NUM_READ read ports, one functional write port and a debug port pair,
// with optional registered reads, write bypass, conflict flag and post-reset clear sweep.
module ram_multiport #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned NUM_READ       = 2,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned BYPASS         = 1,
    parameter int unsigned CLEAR_ON_RESET = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*WIDTH-1:0]      rdata,
    input  logic                           wen,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           debug_write_en,
    input  logic [ADDR_WIDTH-1:0]          debug_write_addr,
    input  logic [WIDTH-1:0]               debug_write_data,
    input  logic [ADDR_WIDTH-1:0]          debug_addr,
    output logic [WIDTH-1:0]               debug_data,
    output logic                           init_done,
    output logic                           wr_conflict
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             wr_conflict_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic                  wr_drop;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Out-of-range addresses read as zero rather than aliasing onto real words.
    function automatic logic [WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
        if (in_range(a)) begin
            return mem[a[IDX_W-1:0]];
        end
        return '0;
    endfunction

    // Debug writer has priority; a colliding functional write is dropped and flagged.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        wr_drop   = 1'b0;
        if (state_q == StRun) begin
            if (debug_write_en) begin
                mem_we    = in_range(debug_write_addr);
                mem_waddr = debug_write_addr;
                mem_wdata = debug_write_data;
                wr_drop   = wen;
            end else if (wen) begin
                mem_we = in_range(waddr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
            ptr_q         <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= wr_drop;
            if (state_q == StClear) begin
                ptr_q <= ptr_q + 1'b1;
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_q <= StRun;
                end
            end
        end
    end

    // Array has no reset so preloaded contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[ptr_q] <= '0;
        end else if (mem_we) begin
            mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
        end
    end

    assign init_done   = (state_q == StRun);
    assign wr_conflict = wr_conflict_q;
    assign debug_data  = rd_word(debug_addr);

    if (READ_LATENCY == 0) begin : g_comb_read
        always_comb begin
            rdata = '0;
            for (int i = 0; i < int'(NUM_READ); i++) begin
                rdata[i*WIDTH +: WIDTH] = rd_word(raddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            end
        end
    end else begin : g_reg_read
        logic [NUM_READ*WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdata_q <= '0;
            end else begin
                for (int i = 0; i < int'(NUM_READ); i++) begin
                    if (state_q == StClear) begin
                        rdata_q[i*WIDTH +: WIDTH] <= '0;
                    end else if ((BYPASS != 0) && mem_we
                                 && (mem_waddr == raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                        rdata_q[i*WIDTH +: WIDTH] <= mem_wdata;
                    end else begin
                        rdata_q[i*WIDTH +: WIDTH] <= rd_word(raddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
                    end
                end
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_ram_multiport.sv
// Bench for ram_multiport: three configurations share one input stream and are compared every
// cycle against array-level models, with directed scenarios pinned by literal expectations.
module tb_ram_multiport;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, rst_b;
    logic [4*AW-1:0] raddr;
    logic          wen, dwe;
    logic [AW-1:0] waddr, dwaddr, daddr;
    logic [W-1:0]  wdata, dwdata;

    logic [4*W-1:0] rdata_a;
    logic [2*W-1:0] rdata_b, rdata_c;
    logic [W-1:0]   dd_a, dd_b, dd_c;
    logic           init_a, init_b, init_c, conf_a, conf_b, conf_c;

    // a: combinational, 4 ports, no clear. b: registered write-first with clear sweep.
    // c: registered read-first, no clear, same reset as a so its contents track a.
    ram_multiport #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_READ(4), .READ_LATENCY(0),
                    .BYPASS(1), .CLEAR_ON_RESET(0)) u_a (
        .clk(clk), .rst(rst_a), .raddr(raddr), .rdata(rdata_a), .wen(wen), .waddr(waddr),
        .wdata(wdata), .debug_write_en(dwe), .debug_write_addr(dwaddr),
        .debug_write_data(dwdata), .debug_addr(daddr), .debug_data(dd_a), .init_done(init_a),
        .wr_conflict(conf_a));
    ram_multiport #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_READ(2), .READ_LATENCY(1),
                    .BYPASS(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst(rst_b), .raddr(raddr[2*AW-1:0]), .rdata(rdata_b), .wen(wen),
        .waddr(waddr), .wdata(wdata), .debug_write_en(dwe), .debug_write_addr(dwaddr),
        .debug_write_data(dwdata), .debug_addr(daddr), .debug_data(dd_b), .init_done(init_b),
        .wr_conflict(conf_b));
    ram_multiport #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_READ(2), .READ_LATENCY(1),
                    .BYPASS(0), .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .rst(rst_a), .raddr(raddr[2*AW-1:0]), .rdata(rdata_c), .wen(wen),
        .waddr(waddr), .wdata(wdata), .debug_write_en(dwe), .debug_write_addr(dwaddr),
        .debug_write_data(dwdata), .debug_addr(daddr), .debug_data(dd_c), .init_done(init_c),
        .wr_conflict(conf_c));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference models: word arrays plus "known" flags for never-written words.
    logic [W-1:0] ma [D];
    bit           va [D];
    logic [W-1:0] mb [D];
    bit           vb [D];
    int           clear_left = 16;
    logic [W-1:0] exp_b [2];
    logic [W-1:0] exp_c [2];
    bit           ev_b [2];
    bit           ev_c [2];
    bit           exp_conf_a = 1'b0;
    bit           exp_conf_b = 1'b0;

    function automatic logic [W-1:0] rd_a(input logic [AW-1:0] a);
        return (a < D) ? ma[a[3:0]] : '0;
    endfunction
    function automatic bit kn_a(input logic [AW-1:0] a);
        return (a >= D) || va[a[3:0]];
    endfunction
    function automatic logic [W-1:0] rd_b(input logic [AW-1:0] a);
        return (a < D) ? mb[a[3:0]] : '0;
    endfunction
    function automatic bit kn_b(input logic [AW-1:0] a);
        return (a >= D) || vb[a[3:0]];
    endfunction

    always @(posedge clk) begin : model
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        bit            hit;
        for (int i = 0; i < 2; i++) begin
            ra = raddr[i*AW +: AW];
            exp_c[i] = rst_a ? rd_a(ra) : '0;
            ev_c[i]  = !rst_a || kn_a(ra);
        end
        exp_conf_a = rst_a && dwe && wen;
        if (dwe) begin
            if (dwaddr < D) begin ma[dwaddr[3:0]] = dwdata; va[dwaddr[3:0]] = 1'b1; end
        end else if (wen && waddr < D) begin
            ma[waddr[3:0]] = wdata; va[waddr[3:0]] = 1'b1;
        end

        if (!rst_b) begin
            clear_left = 16;
            exp_conf_b = 1'b0;
            for (int i = 0; i < 2; i++) begin exp_b[i] = '0; ev_b[i] = 1'b1; end
        end else if (clear_left > 0) begin
            mb[16 - clear_left] = '0;
            vb[16 - clear_left] = 1'b1;
            clear_left--;
            exp_conf_b = 1'b0;
            for (int i = 0; i < 2; i++) begin exp_b[i] = '0; ev_b[i] = 1'b1; end
        end else begin
            wa  = dwe ? dwaddr : waddr;
            wd  = dwe ? dwdata : wdata;
            hit = (dwe || wen) && (wa < D);
            for (int i = 0; i < 2; i++) begin
                ra = raddr[i*AW +: AW];
                if (hit && ra == wa) begin exp_b[i] = wd; ev_b[i] = 1'b1; end
                else begin exp_b[i] = rd_b(ra); ev_b[i] = kn_b(ra); end
            end
            exp_conf_b = dwe && wen;
            if (hit) begin mb[wa[3:0]] = wd; vb[wa[3:0]] = 1'b1; end
        end
    end

    always @(negedge clk) begin : compare
        logic [AW-1:0] ra;
        for (int i = 0; i < 4; i++) begin
            ra = raddr[i*AW +: AW];
            if (kn_a(ra)) chk("a_rdata", rdata_a[i*W +: W], rd_a(ra));
        end
        if (kn_a(daddr)) begin
            chk("a_debug_data", dd_a, rd_a(daddr));
            chk("c_debug_data", dd_c, rd_a(daddr));
        end
        chk("a_init_done", init_a, 1);
        chk("c_init_done", init_c, 1);
        chk("a_wr_conflict", conf_a, rst_a ? exp_conf_a : 1'b0);
        chk("c_wr_conflict", conf_c, rst_a ? exp_conf_a : 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (!rst_a) chk("c_rdata_reset", rdata_c[i*W +: W], 0);
            else if (ev_c[i]) chk("c_rdata", rdata_c[i*W +: W], exp_c[i]);
        end
        if (!rst_b) begin
            chk("b_rdata_reset", rdata_b, 0);
            chk("b_init_reset", init_b, 0);
            chk("b_conf_reset", conf_b, 0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ev_b[i]) chk("b_rdata", rdata_b[i*W +: W], exp_b[i]);
            end
            chk("b_init_done", init_b, clear_left == 0);
            chk("b_wr_conflict", conf_b, exp_conf_b);
        end
        if (kn_b(daddr)) chk("b_debug_data", dd_b, rd_b(daddr));
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with init_done low after rst_b is released, under random ignored writes.
    task automatic sweep(input string name);
        int lows = 0;
        int nz   = 0;
        bit seen = 1'b0;
        rst_b = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wen = 1'b1; waddr = AW'($urandom_range(0, 15)); wdata = $urandom;
            dwe = 1'($urandom_range(0, 1)); dwaddr = AW'($urandom_range(0, 15));
            dwdata = $urandom; raddr = 20'($urandom);
            @(negedge clk);
            if (init_b) begin seen = 1'b1; break; end
            lows++;
            if (rdata_b != '0) nz++;
            next();
        end
        wen = 1'b0; dwe = 1'b0;
        chk({name, "_len"}, lows, 16);
        chk({name, "_done"}, seen, 1);
        chk({name, "_rdata_zero"}, nz, 0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
        dwe = 1'b0; dwaddr = '0; dwdata = '0; daddr = '0;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) next();

        // Preload under reset, then release a/c only.
        dwe = 1'b1; dwaddr = 5'd4; dwdata = 32'd3; next();
        dwaddr = 5'd3; dwdata = 32'd23; next();
        dwe = 1'b0; rst_a = 1'b1; daddr = 5'd3;
        @(negedge clk);
        chk("preload_addr3", dd_a, 32'd23);
        chk("preload_init_done", init_a, 1);
        next();
        daddr = 5'd4;
        @(negedge clk);
        chk("preload_addr4", dd_a, 32'd3);
        next();

        sweep("clear_sweep");
        for (int a = 0; a < D; a++) begin
            daddr = AW'(a);
            #1;
            chk("clear_word_zero", dd_b, 0);
        end
        next();

        // Functional write seen by all four combinational ports.
        wen = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; next();
        wen = 1'b0; raddr = {4{5'd7}};
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("multi_read_7", rdata_a[i*W +: W], 32'hDEADBEEF);
        next();
        raddr[3*AW +: AW] = 5'd20;
        @(negedge clk);
        chk("read_out_of_range", rdata_a[3*W +: W], 0);
        chk("read_port0_still", rdata_a[W-1:0], 32'hDEADBEEF);
        next();

        // Bypass vs read-first on a same-cycle write to the read address.
        wen = 1'b1; waddr = 5'd5; wdata = 32'd11; next();
        wdata = 32'd99; raddr[AW-1:0] = 5'd5; next();
        wen = 1'b0;
        @(negedge clk);
        chk("bypass_write_first", rdata_b[W-1:0], 32'd99);
        chk("bypass_read_first", rdata_c[W-1:0], 32'd11);
        next();
        @(negedge clk);
        chk("read_first_later", rdata_c[W-1:0], 32'd99);
        next();

        // Conflict: debug write wins, functional write dropped, one-cycle flag.
        wen = 1'b1; waddr = 5'd2; wdata = 32'h55; next();
        wdata = 32'd1; dwe = 1'b1; dwaddr = 5'd9; dwdata = 32'd8; next();
        wen = 1'b0; dwe = 1'b0; daddr = 5'd9;
        @(negedge clk);
        chk("conflict_debug_word", dd_a, 32'd8);
        chk("conflict_flag_a", conf_a, 1);
        chk("conflict_flag_b", conf_b, 1);
        daddr = 5'd2;
        #1;
        chk("conflict_func_dropped", dd_a, 32'h55);
        next();
        @(negedge clk);
        chk("conflict_pulse_end", conf_a, 0);
        next();

        // Reset in the middle of a sweep restarts it.
        rst_b = 1'b0; next(); next();
        rst_b = 1'b1; repeat (6) next();
        rst_b = 1'b0; next();
        sweep("midsweep");
        next();

        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] sa;
            for (int i = 0; i < 4; i++) raddr[i*AW +: AW] = AW'($urandom_range(0, 19));
            wen = 1'($urandom_range(0, 1)); waddr = AW'($urandom_range(0, 19));
            wdata = $urandom;
            dwe = ($urandom_range(0, 3) == 0); dwaddr = AW'($urandom_range(0, 19));
            dwdata = $urandom; daddr = AW'($urandom_range(0, 19));
            if ($urandom_range(0, 3) == 0) begin
                sa = dwe ? dwaddr : waddr;
                raddr = {4{sa}};
            end
            rst_a = ($urandom_range(0, 99) != 0);
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_multiport.md
Name: ram_multiport

Overview:
- Parametrised successor to the fixed two-read/one-write RAM2 used under HLS-generated kernels.
- Provides NUM_READ functional read ports, one functional write port, and a debug write/read port pair for testbench preload and inspection.
- Adds selectable read latency, write-to-read bypass, a write-conflict flag, and an optional post-reset clear sequencer.
- Sits between generated kernels (raddr_N/rdata_N/waddr_0/wdata_0/wen_0) and the testbench debug interface.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 16, number of words.
- ADDR_WIDTH, 5, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- NUM_READ, 2, number of functional read ports (1..8).
- READ_LATENCY, 0, 0 = combinational read; 1 = registered read.
- BYPASS, 1, READ_LATENCY=1 only: 1 = write-first, 0 = read-first.
- CLEAR_ON_RESET, 0, 1 = zero all words after reset release; 0 = contents preserved across reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- raddr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_READ*WIDTH  packed read data, same packing.
- wen  in  1  functional write enable.
- waddr  in  ADDR_WIDTH  functional write address.
- wdata  in  WIDTH  functional write data.
- debug_write_en  in  1  debug write enable.
- debug_write_addr  in  ADDR_WIDTH  debug write address.
- debug_write_data  in  WIDTH  debug write data.
- debug_addr  in  ADDR_WIDTH  debug read address.
- debug_data  out  WIDTH  debug read data, always combinational.
- init_done  out  1  high when the memory accepts functional traffic.
- wr_conflict  out  1  one-cycle pulse: debug write dropped a functional write.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to CLEAR if CLEAR_ON_RESET=1, otherwise to RUN.
  - init_done is 0 if CLEAR_ON_RESET=1, otherwise 1.
  - Registered rdata (READ_LATENCY=1) = 0; wr_conflict = 0; clear pointer = 0.
  - Array contents are not touched asynchronously.
- Debug write during reset: with CLEAR_ON_RESET=0, debug writes are honoured on clk edges while rst=0. This is the preload-under-reset flow.
- FSM states:
  - CLEAR: one word per cycle, word[ptr] <= 0, ptr increments. Leave to RUN after ptr == DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles after rst rises. All writes are ignored in CLEAR, and wr_conflict stays 0.
  - RUN: normal operation, init_done = 1. No exit except reset.
- Reset mid-CLEAR: restarts the sweep from 0.
- Write arbitration in RUN, one array write per cycle:
  - debug_write_en=1 wins.
  - If wen=1 in the same cycle, the functional write is dropped and wr_conflict=1 on the next cycle, whatever the addresses.
  - Otherwise wen=1 writes wdata.
  - A write is visible to combinational reads after the edge.
- Out-of-range addresses (>= DEPTH):
  - Writes are ignored.
  - Reads return 0 on rdata and debug_data.
  - No wrap-around.
- READ_LATENCY=0: rdata[i] = word[raddr[i]] combinationally.
- READ_LATENCY=1:
  - rdata[i] registered at the edge from the address presented that cycle.
  - In CLEAR, registered rdata stays 0.
  - Same-cycle write to the same address: BYPASS=1 returns the new data (the winning writer's data); BYPASS=0 returns the old word.
- Multiple read ports may use the same address simultaneously; all return identical data.
- Uninitialised words read X when CLEAR_ON_RESET=0; the bench must not assert on them except as X.

Test Plan:
- Preload under reset (CLEAR_ON_RESET=0): rst=0, debug writes 4<-3 and 3<-23, release rst -> debug_data at addr 3 = 23, at addr 4 = 3; init_done=1 immediately.
- Clear sweep (CLEAR_ON_RESET=1, DEPTH=16): after rst rises -> init_done=0 for exactly 16 cycles, then 1. All addresses read 0. wen during the sweep has no effect.
- Functional write / multi-read (NUM_READ=4, latency 0): wen, waddr=7, wdata=0xDEADBEEF -> after the edge all four ports with raddr=7 read 0xDEADBEEF; a port with raddr=20 reads 0.
- Registered read and bypass (READ_LATENCY=1): word 5 = 11, same cycle write 5<-99 with raddr0=5 -> BYPASS=1 gives rdata0=99 next cycle; BYPASS=0 gives 11, then 99 one cycle later.
- Conflict: wen with 2<-1 and debug write 9<-8 in the same cycle -> word 9 = 8, word 2 unchanged, wr_conflict=1 for exactly one cycle.
- Reset mid-sweep: assert rst at cycle 6 of CLEAR, release -> a full 16-cycle sweep is repeated and registered rdata = 0 throughout.
